led_pwm_source: RTL

LED_PWM_SOURCE -- requirements
Module: led_pwm_source

---
 rtl/led_pkg.sv | 15 +
 rtl/pps_watchdog.sv | 100 ++++++++++
 rtl/led_pwm_source.sv | 75 +++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and default constants for the LED PWM source and its PPS lock watchdog.
package led_pkg;

    typedef enum logic [1:0] {
        LOST    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    localparam int unsigned DEF_PRESCALE    = 47;
    localparam int unsigned DEF_PPS_MIN     = 11_400_000;
    localparam int unsigned DEF_PPS_TIMEOUT = 12_600_000;
    localparam int unsigned DEF_LOCK_PULSES = 3;

endpackage

// File: rtl/pps_watchdog.sv
// Synchronises the GPS PPS input, measures the gap between rising edges and
// tracks lock through LOST -> ACQUIRE -> LOCKED; gps_lost is high unless locked.
module pps_watchdog
    import led_pkg::*;
#(
    parameter int unsigned PPS_MIN     = DEF_PPS_MIN,
    parameter int unsigned PPS_TIMEOUT = DEF_PPS_TIMEOUT,
    parameter int unsigned LOCK_PULSES = DEF_LOCK_PULSES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pps,
    output logic gps_lost
);

    localparam int unsigned CW = $clog2(PPS_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT     = CW'(PPS_TIMEOUT);
    localparam logic [CW-1:0] MIN_GAP     = CW'(PPS_MIN);
    localparam logic [3:0]    GOOD_TARGET = 4'(LOCK_PULSES);

    // [1:0] form the synchroniser, [2] is the previous synchronised level.
    logic [2:0]    sync_q;
    logic [CW-1:0] interval_q;
    logic [3:0]    good_q, good_d;
    lock_state_t   state_q, state_d;
    logic          pps_edge, timeout, short_gap, legal_gap;

    assign pps_edge  = sync_q[1] & ~sync_q[2];
    assign timeout   = (interval_q == TIMEOUT);
    assign short_gap = (interval_q < MIN_GAP);
    assign legal_gap = !short_gap && !timeout;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            interval_q <= TIMEOUT;
            state_q    <= LOST;
            good_q     <= '0;
            gps_lost   <= 1'b1;
        end else begin
            sync_q <= {sync_q[1:0], pps};
            if (pps_edge) begin
                interval_q <= '0;
            end else if (!timeout) begin
                interval_q <= interval_q + 1'b1;
            end
            state_q  <= state_d;
            good_q   <= good_d;
            gps_lost <= (state_q != LOCKED);
        end
    end

    // NOTE: defaults first so every path assigns state_d and good_d; no latches.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            LOST: begin
                if (pps_edge) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                // An edge always wins over a simultaneous timeout.
                if (pps_edge) begin
                    if (legal_gap) begin
                        good_d = good_q + 1'b1;
                        if (good_q + 1'b1 == GOOD_TARGET) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d = LOST;
                end
            end
            LOCKED: begin
                if (pps_edge) begin
                    if (short_gap) begin
                        state_d = LOST;
                    end else if (timeout) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end else if (timeout) begin
                    state_d = LOST;
                end
            end
            default: begin
                state_d = LOST;
                good_d  = '0;
            end
        endcase
    end

endmodule

// File: rtl/led_pwm_source.sv
// 8-bit LED PWM with a prescaled tick, duty updates latched only at period
// boundaries through a one-deep pending slot, plus GPS PPS lock monitoring.
module led_pwm_source
    import led_pkg::*;
#(
    parameter int unsigned PRESCALE    = DEF_PRESCALE,
    parameter int unsigned PPS_MIN     = DEF_PPS_MIN,
    parameter int unsigned PPS_TIMEOUT = DEF_PPS_TIMEOUT,
    parameter int unsigned LOCK_PULSES = DEF_LOCK_PULSES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    input  logic       pps,
    output logic       on,
    output logic       gps_lost
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;
    logic [7:0]    phase_q, active_q, pending_q;
    logic          pending_valid_q;
    logic          tick, boundary, transfer;

    assign tick       = (presc_q == PRESCALE_LAST);
    assign boundary   = tick && (phase_q == 8'hFF);
    assign duty_ready = rst_n && !pending_valid_q;
    assign transfer   = duty_valid && duty_ready;

    // NOTE: the duty registers sit in the reset branch alongside the counters,
    // so a reset can never leave a stale brightness waiting to be applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q         <= '0;
            phase_q         <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            on              <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                phase_q <= phase_q + 1'b1;
            end
            // The pending slot is full whenever ready is low, so a boundary
            // copy and a new capture never collide.
            if (boundary && pending_valid_q) begin
                active_q <= pending_q;
            end
            if (transfer) begin
                pending_q       <= duty_in;
                pending_valid_q <= 1'b1;
            end else if (boundary) begin
                pending_valid_q <= 1'b0;
            end
            on <= (phase_q < active_q);
        end
    end

    pps_watchdog #(
        .PPS_MIN     (PPS_MIN),
        .PPS_TIMEOUT (PPS_TIMEOUT),
        .LOCK_PULSES (LOCK_PULSES)
    ) u_pps_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .pps      (pps),
        .gps_lost (gps_lost)
    );

endmodule
